// File: rtl/nkmd_dai_rx.sv
// Audio receive buffer: a 64x24 ring filled by the sample strobe and drained
// by CPU shift writes. The CPU reads the unread count, or any sample at an
// offset relative to the oldest unread entry.
module nkmd_dai_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] rx_data_i,
  input  logic        rx_ack_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic [31:0] addr_i,
  input  logic        we_i
);

  localparam int unsigned DW    = 24;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned BW    = 32;

  logic [DW-1:0] ring_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] unread_q, unread_d;
  logic [BW-1:0] data_q, data_d;

  logic          ctrl_sel_c;
  logic          ring_sel_c;
  logic          push_c;
  logic          shift_c;
  logic [AW-1:0] rd_idx_c;

  // Bits with no function: write data and the upper address bits.
  logic          unused_c;
  assign unused_c = ^{data_i, addr_i[31:16]};

  // Address decode and the push/shift qualifiers.
  always_comb begin
    ctrl_sel_c = (addr_i[15:12] == 4'hd) && (addr_i[11:0] == 12'd0);
    ring_sel_c = (addr_i[15:12] == 4'hf);
    push_c     = !rst && rx_ack_i && (unread_q != AW'(DEPTH - 1));
    shift_c    = !rst && we_i && ctrl_sel_c && (unread_q != AW'(0));
    rd_idx_c   = rd_ptr_q + addr_i[AW-1:0];
  end

  // Next-state of the pointers and count; a push and a shift together cancel in the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    unread_d = unread_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (shift_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_c, shift_c})
      2'b10:   unread_d = unread_q + AW'(1);
      2'b01:   unread_d = unread_q - AW'(1);
      default: unread_d = unread_q;
    endcase
  end

  // Read mux, evaluated against the pre-update read pointer.
  always_comb begin
    data_d = '0;
    if (ctrl_sel_c) begin
      data_d = BW'(unread_q);
    end else if (ring_sel_c) begin
      data_d = BW'(ring_q[rd_idx_c]);
    end
  end

  // Pointer, count and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      unread_q <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      unread_q <= unread_d;
      data_q   <= data_d;
    end
  end

  // Sample storage; left unreset so it can map onto a RAM.
  always_ff @(posedge clk) begin
    if (push_c) begin
      ring_q[wr_ptr_q] <= rx_data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_nkmd_dai_rx.sv
// Directed and random checks of nkmd_dai_rx against a queue model of the
// unread samples.
module tb_nkmd_dai_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] rx_data_i = '0;
  logic        rx_ack_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;

  int errors = 0;
  int checks = 0;

  // Unread samples, oldest first.
  logic [23:0] mq[$];

  localparam logic [31:0] CTRL = 32'h0000_d000;

  nkmd_dai_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data_i (rx_data_i),
    .rx_ack_i  (rx_ack_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .addr_i    (addr_i),
    .we_i      (we_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read result from the model state before the edge.
  task automatic model_read(input logic [31:0] a, output logic [31:0] exp, output bit en);
    int off;
    en  = 1'b1;
    exp = '0;
    if (a[15:12] == 4'hd && a[11:0] == 12'd0) begin
      exp = 32'(mq.size());
    end else if (a[15:12] == 4'hf) begin
      off = int'(a[5:0]);
      if (off < mq.size()) exp = {8'h00, mq[off]};
      else en = 1'b0;
    end
  endtask

  // One clock with the given inputs; the model updates and the read is checked.
  task automatic step(input logic ack, input logic [23:0] d, input logic w, input logic [31:0] a);
    logic [31:0] exp;
    bit          en;
    bit          do_push;
    bit          do_shift;
    rx_ack_i  = ack;
    rx_data_i = d;
    we_i      = w;
    addr_i    = a;
    data_i    = $urandom;
    model_read(a, exp, en);
    do_push  = ack && (mq.size() < 63);
    do_shift = w && (a[15:12] == 4'hd) && (a[11:0] == 12'd0) && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (do_shift) void'(mq.pop_front());
    if (do_push) mq.push_back(d);
    if (en) chk($sformatf("read@%h", a), data_o, exp);
    rx_ack_i = 1'b0;
    we_i     = 1'b0;
  endtask

  task automatic push(input logic [23:0] d);
    step(1'b1, d, 1'b0, 32'h0);
  endtask

  task automatic shift();
    step(1'b0, 24'h0, 1'b1, CTRL);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, 24'h0, 1'b0, a);
  endtask

  // Reset with push and shift requested, which must both be ignored.
  task automatic do_reset();
    rst = 1'b1; rx_ack_i = 1'b1; rx_data_i = 24'h123456; we_i = 1'b1; addr_i = CTRL;
    @(posedge clk);
    #1;
    mq.delete();
    rst = 1'b0; rx_ack_i = 1'b0; we_i = 1'b0;
    chk("reset_data_o", data_o, 32'h0);
  endtask

  initial begin
    // After reset.
    do_reset();
    rd(CTRL);
    chk("count_after_reset", data_o, 32'h0);

    // Single sample.
    push(24'hcafebb);
    rd(CTRL);
    chk("count_one", data_o, 32'h1);
    rd(32'h0000_f000);
    chk("first_sample", data_o, 32'h00cafebb);

    // Five more, then shift out the first.
    for (int i = 0; i < 5; i++) push(24'hbeef00 + 24'(i));
    shift();
    rd(CTRL);
    chk("count_five", data_o, 32'h5);
    for (int i = 0; i < 5; i++) rd(32'h0000_f000 + 32'(i));
    shift();
    for (int i = 0; i < 4; i++) rd(32'h0000_f000 + 32'(i));
    chk("offset3_after_shift", data_o, 32'h00beef04);
    for (int i = 0; i < 4; i++) shift();
    rd(CTRL);
    chk("count_drained", data_o, 32'h0);

    // Fill, partial drain and pointer wrap.
    for (int i = 0; i < 63; i++) push(24'(i));
    rd(CTRL);
    chk("count_full", data_o, 32'd63);
    for (int i = 0; i < 59; i++) shift();
    rd(CTRL);
    chk("count_four", data_o, 32'd4);
    for (int i = 63; i < 67; i++) push(24'(i));
    rd(CTRL);
    chk("count_eight", data_o, 32'd8);
    for (int i = 0; i < 8; i++) begin
      rd(32'h0000_f000);
      chk($sformatf("wrap_order%0d", i), data_o, 32'(59 + i));
      shift();
    end

    // Push while full drops the sample; shift while empty does nothing.
    for (int i = 0; i < 63; i++) push(24'h100 + 24'(i));
    push(24'h777777);
    rd(CTRL);
    chk("count_stays_full", data_o, 32'd63);
    rd(32'h0000_f03e);
    chk("full_last_kept", data_o, 32'h0000013e);
    for (int i = 0; i < 63; i++) shift();
    shift();
    rd(CTRL);
    chk("count_stays_empty", data_o, 32'h0);

    // Simultaneous push and shift: normal, when full, when empty.
    push(24'haaaaaa);
    push(24'hbbbbbb);
    step(1'b1, 24'hcccccc, 1'b1, CTRL);
    rd(CTRL);
    chk("count_simul", data_o, 32'd2);
    rd(32'h0000_f000);
    chk("simul_head", data_o, 32'h00bbbbbb);
    rd(32'h0000_f001);
    chk("simul_tail", data_o, 32'h00cccccc);
    while (mq.size() < 63) push(24'($urandom));
    step(1'b1, 24'hdddddd, 1'b1, CTRL);
    rd(CTRL);
    chk("simul_full", data_o, 32'd62);
    while (mq.size() > 0) shift();
    step(1'b1, 24'heeeeee, 1'b1, CTRL);
    rd(CTRL);
    chk("simul_empty", data_o, 32'd1);
    rd(32'h0000_f000);
    chk("simul_empty_data", data_o, 32'h00eeeeee);

    // Writes elsewhere are ignored.
    step(1'b0, 24'h0, 1'b1, 32'h0000_d004);
    step(1'b0, 24'h0, 1'b1, 32'h0000_f000);
    rd(CTRL);
    chk("other_write_ignored", data_o, 32'd1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      int sel;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0, 1:    a = CTRL;
        2, 3:    a = 32'h0000_f000 | 32'($urandom_range(0, 63));
        4:       a = 32'h0000_d000 | 32'($urandom_range(1, 4095));
        default: a = $urandom;
      endcase
      step(1'($urandom_range(0, 99) < 55), 24'($urandom), 1'($urandom_range(0, 99) < 45), a);
    end

    // Reset mid-stream discards everything.
    for (int i = 0; i < 5; i++) push(24'h500 + 24'(i));
    do_reset();
    rd(CTRL);
    chk("count_after_midreset", data_o, 32'h0);
    push(24'h654321);
    rd(32'h0000_f000);
    chk("data_after_midreset", data_o, 32'h00654321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
